core_wb: RTL and testbench



---
 rtl/core_pkg.sv | 32 +++
 rtl/core_wb_instret.sv | 20 ++
 rtl/core_wb.sv | 148 ++++++++++++++
 tb/tb_core_wb.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline: widths, register index type,
// write-back state encoding and the MA->WB bundle.
package core_pkg;

  localparam int XLEN   = 32;
  localparam int CSR_AW = 12;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    HOLD     = 2'd1,
    CSR_WAIT = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   reg_data;
    logic [XLEN-1:0]   mem_data;
    logic [XLEN-1:0]   csr_data;
    reg_idx_t          rd;
    logic [CSR_AW-1:0] csr;
    logic              reg_write;
    logic              csr_write;
    logic              mem_read;
  } mw_bus_t;

  // Result for rd: load data for loads, otherwise the ALU/CSR-read value.
  function automatic logic [XLEN-1:0] sel_wdata(input mw_bus_t bus);
    return bus.mem_read ? bus.mem_data : bus.reg_data;
  endfunction

endpackage

// File: rtl/core_wb_instret.sv
// 64-bit retired-instruction counter; only instantiated under CORE_WB_INSTRET_EN.
module core_wb_instret (
  input  logic        clk,
  input  logic        rest,
  input  logic        inc,
  output logic [63:0] count
);

  // Counter register, wraps naturally from all-ones to zero.
  always_ff @(posedge clk) begin
    if (rest) begin
      count <= 64'd0;
    end else if (inc) begin
      count <= count + 64'd1;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/core_wb.sv
// Write-back stage: single-entry stage register committing to the register file
// and a handshaked CSR write port. Optional macro CORE_WB_INSTRET_EN adds instret.
module core_wb #(
  parameter int XLEN   = core_pkg::XLEN,
  parameter int CSR_AW = core_pkg::CSR_AW
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              mw_valid,
  output logic              mw_ready,
  input  logic [XLEN-1:0]   mw_reg_data,
  input  logic [XLEN-1:0]   mw_mem_data,
  input  logic [XLEN-1:0]   mw_csr_data,
  input  logic [4:0]        mw_rd,
  input  logic [CSR_AW-1:0] mw_csr,
  input  logic              mw_reg_write,
  input  logic              mw_csr_write,
  input  logic              mw_mem_read,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              csr_wr_valid,
  input  logic              csr_wr_ready,
  output logic [CSR_AW-1:0] csr_waddr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              fwd_valid,
  output logic [4:0]        fwd_rd,
  output logic [XLEN-1:0]   fwd_data,
  output logic              retire
`ifdef CORE_WB_INSTRET_EN
  ,
  output logic [63:0]       instret
`endif
);

  import core_pkg::*;

  wb_state_e         state_r;
  wb_state_e         state_nxt_s;
  logic [XLEN-1:0]   wdata_r;
  reg_idx_t          rd_r;
  logic              reg_write_r;
  logic [CSR_AW-1:0] csr_r;
  logic [XLEN-1:0]   csr_data_r;
  logic              csr_write_r;

  logic              full_s;
  logic              commit_s;
  logic              capture_s;
  wb_state_e         entry_state_s;
  mw_bus_t           mw_bus_s;

  assign mw_bus_s = '{
    reg_data:  mw_reg_data,
    mem_data:  mw_mem_data,
    csr_data:  mw_csr_data,
    rd:        mw_rd,
    csr:       mw_csr,
    reg_write: mw_reg_write,
    csr_write: mw_csr_write,
    mem_read:  mw_mem_read
  };

  // Commit/handshake decode and next-state selection from the held entry.
  always_comb begin
    full_s        = 1'b0;
    commit_s      = 1'b0;
    capture_s     = 1'b0;
    entry_state_s = HOLD;
    state_nxt_s   = state_r;

    full_s    = (state_r != EMPTY);
    commit_s  = full_s && (!csr_write_r || csr_wr_ready);
    // Ready never looks at mw_valid, so no valid->ready combinational path.
    mw_ready  = !full_s || commit_s;
    capture_s = mw_valid && mw_ready;

    if (mw_csr_write) begin
      entry_state_s = CSR_WAIT;
    end else begin
      entry_state_s = HOLD;
    end

    case (state_r)
      EMPTY: begin
        if (capture_s) begin
          state_nxt_s = entry_state_s;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      HOLD, CSR_WAIT: begin
        if (commit_s && capture_s) begin
          state_nxt_s = entry_state_s;
        end else if (commit_s) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = EMPTY;
    endcase

    retire       = commit_s;
    rf_we        = commit_s && reg_write_r;
    rf_waddr     = rd_r;
    rf_wdata     = wdata_r;
    csr_wr_valid = full_s && csr_write_r;
    csr_waddr    = csr_r;
    csr_wdata    = csr_data_r;
    fwd_valid    = full_s && reg_write_r;
    fwd_rd       = rd_r;
    fwd_data     = wdata_r;
  end

  // Stage register; a commit and a capture in the same cycle simply reload it.
  always_ff @(posedge clk) begin
    if (rest) begin
      state_r     <= EMPTY;
      wdata_r     <= '0;
      rd_r        <= 5'd0;
      reg_write_r <= 1'b0;
      csr_r       <= '0;
      csr_data_r  <= '0;
      csr_write_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (capture_s) begin
        wdata_r     <= sel_wdata(mw_bus_s);
        rd_r        <= mw_bus_s.rd;
        reg_write_r <= mw_bus_s.reg_write && (mw_bus_s.rd != 5'd0);
        csr_r       <= mw_bus_s.csr;
        csr_data_r  <= mw_bus_s.csr_data;
        csr_write_r <= mw_bus_s.csr_write;
      end
    end
  end

`ifdef CORE_WB_INSTRET_EN
  core_wb_instret u_instret (
    .clk   (clk),
    .rest  (rest),
    .inc   (commit_s),
    .count (instret)
  );
`endif

endmodule

// File: tb/tb_core_wb.sv
// Randomised and directed bench for core_wb against a queue-based retirement model.
module tb_core_wb;

  logic        clk = 1'b0;
  logic        rest;
  logic        mw_valid;
  logic        mw_ready;
  logic [31:0] mw_reg_data, mw_mem_data, mw_csr_data;
  logic [4:0]  mw_rd;
  logic [11:0] mw_csr;
  logic        mw_reg_write, mw_csr_write, mw_mem_read;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        csr_wr_valid, csr_wr_ready;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        retire;
`ifdef CORE_WB_INSTRET_EN
  logic [63:0] instret;
`endif

  always #5 clk = ~clk;

  core_wb dut (
    .clk(clk), .rest(rest), .mw_valid(mw_valid), .mw_ready(mw_ready),
    .mw_reg_data(mw_reg_data), .mw_mem_data(mw_mem_data), .mw_csr_data(mw_csr_data),
    .mw_rd(mw_rd), .mw_csr(mw_csr), .mw_reg_write(mw_reg_write),
    .mw_csr_write(mw_csr_write), .mw_mem_read(mw_mem_read),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_wr_valid(csr_wr_valid), .csr_wr_ready(csr_wr_ready),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retire(retire)
`ifdef CORE_WB_INSTRET_EN
    , .instret(instret)
`endif
  );

  // One in-flight instruction as the spec describes it, not as the RTL stores it.
  typedef struct {
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        rw;
    logic [11:0] csr;
    logic [31:0] cdata;
    logic        cw;
  } ent_t;

  ent_t        q[$];
  int          err_cnt = 0;
  int          chk_cnt = 0;
  longint unsigned exp_instret = 0;
  int          n_cwv, n_nrdy, n_ret, n_rfwe;
  logic        exp_ready_last = 1'b1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [31:0] rdat, input logic [31:0] mdat,
                        input logic [31:0] cdat, input logic [4:0] rd, input logic [11:0] csr,
                        input logic rw, input logic cw, input logic mr);
    mw_valid = v; mw_reg_data = rdat; mw_mem_data = mdat; mw_csr_data = cdat;
    mw_rd = rd; mw_csr = csr; mw_reg_write = rw; mw_csr_write = cw; mw_mem_read = mr;
  endtask

  task automatic idle();
    set_in(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 12'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Checks outputs against the model, then advances the model across one edge.
  task automatic cycle();
    ent_t e;
    logic full, cmt, rdy;
    e = '{wdata: 32'd0, rd: 5'd0, rw: 1'b0, csr: 12'd0, cdata: 32'd0, cw: 1'b0};
    #1;
    full = (q.size() != 0);
    cmt  = 1'b0;
    if (full) begin
      e   = q[0];
      cmt = !e.cw || csr_wr_ready;
    end
    rdy = !full || cmt;
    if (!rest) begin
      check_eq("mw_ready", {63'd0, mw_ready}, {63'd0, rdy});
      check_eq("retire", {63'd0, retire}, {63'd0, cmt});
      check_eq("rf_we", {63'd0, rf_we}, {63'd0, cmt && e.rw});
      if (cmt && e.rw) begin
        check_eq("rf_waddr", {59'd0, rf_waddr}, {59'd0, e.rd});
        check_eq("rf_wdata", {32'd0, rf_wdata}, {32'd0, e.wdata});
      end
      check_eq("csr_wr_valid", {63'd0, csr_wr_valid}, {63'd0, full && e.cw});
      if (full && e.cw) begin
        check_eq("csr_waddr", {52'd0, csr_waddr}, {52'd0, e.csr});
        check_eq("csr_wdata", {32'd0, csr_wdata}, {32'd0, e.cdata});
      end
      check_eq("fwd_valid", {63'd0, fwd_valid}, {63'd0, full && e.rw});
      if (full && e.rw) begin
        check_eq("fwd_rd", {59'd0, fwd_rd}, {59'd0, e.rd});
        check_eq("fwd_data", {32'd0, fwd_data}, {32'd0, e.wdata});
      end
`ifdef CORE_WB_INSTRET_EN
      check_eq("instret", instret, exp_instret);
`endif
      n_cwv  += int'(csr_wr_valid);
      n_nrdy += int'(!mw_ready);
      n_ret  += int'(retire);
      n_rfwe += int'(rf_we);
    end
    exp_ready_last = rdy;
    @(posedge clk);
    if (rest) begin
      q.delete();
      exp_instret = 0;
    end else begin
      if (cmt) begin
        void'(q.pop_front());
        exp_instret++;
      end
      if (mw_valid && rdy) begin
        e.wdata = mw_mem_read ? mw_mem_data : mw_reg_data;
        e.rd    = mw_rd;
        e.rw    = mw_reg_write && (mw_rd != 5'd0);
        e.csr   = mw_csr;
        e.cdata = mw_csr_data;
        e.cw    = mw_csr_write;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic clr_counts();
    n_cwv = 0; n_nrdy = 0; n_ret = 0; n_rfwe = 0;
  endtask

  task automatic do_reset();
    rest = 1'b1;
    idle();
    csr_wr_ready = 1'b1;
    cycle();
    cycle();
    rest = 1'b0;
  endtask

  initial begin
    rest = 1'b1;
    idle();
    csr_wr_ready = 1'b1;
    clr_counts();
    @(negedge clk);
    do_reset();

    // Reset state.
    #1;
    check_eq("rst_mw_ready", {63'd0, mw_ready}, 64'd1);
    check_eq("rst_rf_we", {63'd0, rf_we}, 64'd0);
    check_eq("rst_csr_valid", {63'd0, csr_wr_valid}, 64'd0);
    check_eq("rst_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    check_eq("rst_retire", {63'd0, retire}, 64'd0);
    check_eq("rst_rf_waddr", {59'd0, rf_waddr}, 64'd0);
    check_eq("rst_rf_wdata", {32'd0, rf_wdata}, 64'd0);
    check_eq("rst_csr_waddr", {52'd0, csr_waddr}, 64'd0);
    check_eq("rst_csr_wdata", {32'd0, csr_wdata}, 64'd0);
    check_eq("rst_fwd_data", {32'd0, fwd_data}, 64'd0);
`ifdef CORE_WB_INSTRET_EN
    check_eq("rst_instret", instret, 64'd0);
`endif

    // Load then ALU back to back.
    clr_counts();
    set_in(1'b1, 32'h0000_1111, 32'hDEAD_BEEF, 32'd0, 5'd5, 12'd0, 1'b1, 1'b0, 1'b1);
    cycle();
    set_in(1'b1, 32'h0000_0012, 32'h0000_7777, 32'd0, 5'd6, 12'd0, 1'b1, 1'b0, 1'b0);
    #1;
    check_eq("load_x5_data", {32'd0, rf_wdata}, 64'hDEAD_BEEF);
    cycle();
    idle();
    #1;
    check_eq("alu_x6_data", {32'd0, rf_wdata}, 64'h12);
    cycle();
    check_eq("load_alu_rfwe", 64'(n_rfwe), 64'd2);
    check_eq("load_alu_nrdy", 64'(n_nrdy), 64'd0);

    // rd = 0 is retired but never written or forwarded.
    set_in(1'b1, 32'h0000_0055, 32'd0, 32'd0, 5'd0, 12'd0, 1'b1, 1'b0, 1'b0);
    cycle();
    idle();
    #1;
    check_eq("rd0_rf_we", {63'd0, rf_we}, 64'd0);
    check_eq("rd0_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    check_eq("rd0_retire", {63'd0, retire}, 64'd1);
    cycle();

    // CSR stall of three cycles, next instruction held by MA meanwhile.
    set_in(1'b1, 32'h0000_0003, 32'd0, 32'h0000_0008, 5'd7, 12'h300, 1'b1, 1'b1, 1'b0);
    cycle();
    set_in(1'b1, 32'h0000_00A1, 32'd0, 32'd0, 5'd9, 12'd0, 1'b1, 1'b0, 1'b0);
    clr_counts();
    csr_wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    csr_wr_ready = 1'b1;
    #1;
    check_eq("stall_x7_addr", {59'd0, rf_waddr}, 64'd7);
    cycle();
    check_eq("stall_csr_valid_cycles", 64'(n_cwv), 64'd4);
    check_eq("stall_not_ready_cycles", 64'(n_nrdy), 64'd3);
    check_eq("stall_retire_cycles", 64'(n_ret), 64'd1);
    idle();
    #1;
    check_eq("cc_next_rd", {59'd0, rf_waddr}, 64'd9);
    cycle();

    // Reset while in CSR_WAIT drops the instruction.
    set_in(1'b1, 32'h0000_0004, 32'd0, 32'h0000_00FF, 5'd3, 12'h341, 1'b1, 1'b1, 1'b0);
    cycle();
    idle();
    csr_wr_ready = 1'b0;
    cycle();
    rest = 1'b1;
    cycle();
    rest = 1'b0;
    csr_wr_ready = 1'b1;
    #1;
    check_eq("rstw_csr_valid", {63'd0, csr_wr_valid}, 64'd0);
    check_eq("rstw_mw_ready", {63'd0, mw_ready}, 64'd1);
    check_eq("rstw_retire", {63'd0, retire}, 64'd0);
    check_eq("rstw_rf_we", {63'd0, rf_we}, 64'd0);
    cycle();

`ifdef CORE_WB_INSTRET_EN
    // Ten retirements around one CSR stall.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 32'(i + 100), 32'd0, 32'(i), 5'(i + 1), 12'h305, 1'b1, (i == 4), 1'b0);
      csr_wr_ready = 1'b1;
      if (i == 5) begin
        csr_wr_ready = 1'b0;
        cycle();
        cycle();
        csr_wr_ready = 1'b1;
      end
      cycle();
    end
    idle();
    for (int i = 0; i < 3; i++) cycle();
    #1;
    check_eq("instret_ten", instret, 64'd10);
`endif

    // Random traffic; MA holds its outputs while stalled.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (!(mw_valid && !exp_ready_last)) begin
        set_in(($urandom_range(0, 9) < 7), $urandom, $urandom, $urandom,
               5'($urandom_range(0, 31) < 4 ? 0 : $urandom_range(1, 31)),
               12'($urandom), 1'($urandom), ($urandom_range(0, 9) < 3), 1'($urandom));
      end
      csr_wr_ready = ($urandom_range(0, 9) < 6);
      rest = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rest = 1'b0;

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
